div_unit: RTL and testbench

- Iterative radix-2 restoring divider for RV32M DIV/DIVU/REM/REMU. Sits in the EXE stage beside the ALU.
- Consumes the divide-instruction flag and fun3 decoded by the control unit. Produces divide_stall, which the pipeline controller uses to freeze PC/IF/ID/EXE until the result is ready.
- The result is muxed into the EXE result path in the cycle divide_stall drops.

---
 rtl/div_pkg.sv | 22 ++
 rtl/div_step.sv | 32 +++
 rtl/div_unit.sv | 152 +++++++++++++++
 tb/tb_div_unit.sv | 211 +++++++++++++++++++++
 4 files changed

// File: rtl/div_pkg.sv
// div_pkg: shared types and constants for the RV32M iterative divider.
// Used by div_unit and div_step (optional early-out build: DIV_EARLY_OUT_EN).
package div_pkg;

    localparam int DIV_XLEN    = 32;
    localparam int DIV_LATENCY = DIV_XLEN + 2;

    typedef enum logic [2:0] {
        DIV  = 3'b100,
        DIVU = 3'b101,
        REM  = 3'b110,
        REMU = 3'b111
    } div_op_t;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        BUSY = 2'd1,
        FIX  = 2'd2,
        DONE = 2'd3
    } div_state_t;

endpackage

// File: rtl/div_step.sv
// div_step: one combinational radix-2 restoring iteration on {rem, quo}.
// The shifted partial remainder is XLEN+1 bits wide so the trial subtraction
// never loses its sign bit.
module div_step
    import div_pkg::*;
#(
    parameter int XLEN = DIV_XLEN
) (
    input  logic [XLEN-1:0] i_rem,
    input  logic [XLEN-1:0] i_quo,
    input  logic [XLEN-1:0] i_divisor_mag,
    output logic [XLEN-1:0] o_rem,
    output logic [XLEN-1:0] o_quo
);

    logic [XLEN:0] w_rem_sh;
    logic [XLEN:0] w_trial;

    assign w_rem_sh = {i_rem, i_quo[XLEN-1]};
    assign w_trial  = w_rem_sh - {1'b0, i_divisor_mag};

    // Keep the trial difference when it is non-negative, otherwise restore.
    always_comb begin
        o_rem = w_rem_sh[XLEN-1:0];
        o_quo = {i_quo[XLEN-2:0], 1'b0};
        if (!w_trial[XLEN]) begin
            o_rem = w_trial[XLEN-1:0];
            o_quo = {i_quo[XLEN-2:0], 1'b1};
        end
    end

endmodule

// File: rtl/div_unit.sv
// div_unit: iterative restoring divider for RV32M DIV/DIVU/REM/REMU in EXE.
// Operates on magnitudes and applies the sign fix in a final FIX cycle.
// Optional build macro DIV_EARLY_OUT_EN: divide-by-zero, signed overflow and
// |dividend| < |divisor| finish straight from IDLE into DONE.
module div_unit
    import div_pkg::*;
#(
    parameter int XLEN  = DIV_XLEN,
    parameter int CNT_W = $clog2(XLEN)
) (
    input  logic            clk,
    input  logic            reset,
    input  logic            start,
    input  logic [2:0]      fun3,
    input  logic [XLEN-1:0] dividend,
    input  logic [XLEN-1:0] divisor,
    input  logic            flush,
    output logic [XLEN-1:0] result,
    output logic            done,
    output logic            divide_stall
);

    div_state_t       r_state, w_state_nxt;
    logic [CNT_W-1:0] r_count;
    logic [XLEN-1:0]  r_rem, r_quo, r_dvs_mag, r_result;
    logic [2:0]       r_op;
    logic             r_sign_q, r_sign_r, r_div_zero;

    logic             w_signed_in, w_r_signed, w_r_sel_rem;
    logic [XLEN-1:0]  w_dvd_mag, w_dvs_mag;
    logic [XLEN-1:0]  w_rem_nxt, w_quo_nxt;
    logic [XLEN-1:0]  w_quo_fix, w_rem_fix;
    logic             w_early;
    logic [XLEN-1:0]  w_early_result;

    // Two's-complement magnitude; the most negative value maps to itself,
    // which is the correct unsigned magnitude.
    function automatic logic [XLEN-1:0] mag(input logic [XLEN-1:0] v,
                                            input logic            is_signed);
        return (is_signed && v[XLEN-1]) ? (~v + 1'b1) : v;
    endfunction

    assign w_signed_in = ~fun3[0];
    assign w_dvd_mag   = mag(dividend, w_signed_in);
    assign w_dvs_mag   = mag(divisor, w_signed_in);

    assign w_r_signed  = (r_op == DIV) || (r_op == REM);
    assign w_r_sel_rem = (r_op == REM) || (r_op == REMU);

    // Divide by zero leaves quo all ones; suppressing its negation gives -1.
    assign w_quo_fix = (r_sign_q && !r_div_zero) ? (~r_quo + 1'b1) : r_quo;
    assign w_rem_fix = r_sign_r ? (~r_rem + 1'b1) : r_rem;

    div_step #(.XLEN(XLEN)) u_step (
        .i_rem         (r_rem),
        .i_quo         (r_quo),
        .i_divisor_mag (r_dvs_mag),
        .o_rem         (w_rem_nxt),
        .o_quo         (w_quo_nxt)
    );

`ifdef DIV_EARLY_OUT_EN
    logic w_dz_in, w_ovf_in, w_small_in;

    assign w_dz_in    = (divisor == '0);
    assign w_ovf_in   = w_signed_in && (dividend == {1'b1, {(XLEN-1){1'b0}}})
                        && (divisor == '1);
    assign w_small_in = (w_dvd_mag < w_dvs_mag);
    assign w_early    = w_dz_in || w_ovf_in || w_small_in;

    // Resolve the special cases directly from the raw operands.
    always_comb begin
        w_early_result = fun3[1] ? dividend : '0;
        if (w_dz_in)
            w_early_result = fun3[1] ? dividend : '1;
        else if (w_ovf_in)
            w_early_result = fun3[1] ? '0 : dividend;
    end
`else
    assign w_early        = 1'b0;
    assign w_early_result = '0;
`endif

    // Next-state logic; flush aborts from any state.
    always_comb begin
        w_state_nxt = r_state;
        if (flush) begin
            w_state_nxt = IDLE;
        end else begin
            case (r_state)
                IDLE:    if (start) w_state_nxt = w_early ? DONE : BUSY;
                BUSY:    if (r_count == '0) w_state_nxt = FIX;
                FIX:     w_state_nxt = DONE;
                DONE:    w_state_nxt = IDLE;
                default: w_state_nxt = IDLE;
            endcase
        end
    end

    // State register.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) r_state <= IDLE;
        else       r_state <= w_state_nxt;
    end

    // Operand capture, per-cycle iteration and final result register.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_count    <= '0;
            r_rem      <= '0;
            r_quo      <= '0;
            r_dvs_mag  <= '0;
            r_result   <= '0;
            r_op       <= '0;
            r_sign_q   <= 1'b0;
            r_sign_r   <= 1'b0;
            r_div_zero <= 1'b0;
        end else begin
            case (r_state)
                IDLE: begin
                    if (start && !flush) begin
                        r_rem      <= '0;
                        r_quo      <= w_dvd_mag;
                        r_dvs_mag  <= w_dvs_mag;
                        r_sign_q   <= w_signed_in & (dividend[XLEN-1] ^ divisor[XLEN-1]);
                        r_sign_r   <= w_signed_in & dividend[XLEN-1];
                        r_div_zero <= (divisor == '0);
                        r_op       <= fun3;
                        r_count    <= CNT_W'(XLEN - 1);
                        if (w_early) r_result <= w_early_result;
                    end
                end
                BUSY: begin
                    r_rem   <= w_rem_nxt;
                    r_quo   <= w_quo_nxt;
                    r_count <= r_count - CNT_W'(1);
                end
                FIX: begin
                    if (w_r_signed) r_result <= w_r_sel_rem ? w_rem_fix : w_quo_fix;
                    else            r_result <= w_r_sel_rem ? r_rem : r_quo;
                end
                default: ;
            endcase
        end
    end

    assign done         = (r_state == DONE);
    assign result       = (r_state == DONE) ? r_result : '0;
    assign divide_stall = !flush && (((r_state == IDLE) && start) ||
                                     (r_state == BUSY) || (r_state == FIX));

endmodule

// File: tb/tb_div_unit.sv
// tb_div_unit: directed bench for div_unit with an arithmetic reference model
// and a per-cycle compare of divide_stall, done and result.
module tb_div_unit;
    import div_pkg::*;

    logic        clk = 1'b0;
    logic        reset, start, flush;
    logic [2:0]  fun3;
    logic [31:0] dividend, divisor, result;
    logic        done, divide_stall;

    int          cyc = 0;
    int          checks = 0;
    int          errors = 0;

    // Expected-transaction state, written only by the driver branch.
    bit          exp_active = 1'b0;
    int          exp_done_cyc = 0;
    logic [31:0] exp_res = '0;

`ifdef DIV_EARLY_OUT_EN
    localparam bit EARLY = 1'b1;
`else
    localparam bit EARLY = 1'b0;
`endif

    div_unit dut (
        .clk          (clk),
        .reset        (reset),
        .start        (start),
        .fun3         (fun3),
        .dividend     (dividend),
        .divisor      (divisor),
        .flush        (flush),
        .result       (result),
        .done         (done),
        .divide_stall (divide_stall)
    );

    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    initial begin
        #200000;
        $display("FAIL watchdog: simulation exceeded time budget");
        $fatal(1);
    end

    // RISC-V M-extension semantics expressed with plain arithmetic.
    function automatic logic [31:0] model(input logic [2:0] f,
                                          input logic [31:0] a,
                                          input logic [31:0] b);
        logic signed [31:0] sa, sb;
        sa = a;
        sb = b;
        if (b == 32'd0) return f[1] ? a : 32'hFFFF_FFFF;
        if (!f[0] && a == 32'h8000_0000 && b == 32'hFFFF_FFFF)
            return f[1] ? 32'd0 : 32'h8000_0000;
        case (f[1:0])
            2'b00:   return sa / sb;
            2'b01:   return a / b;
            2'b10:   return sa % sb;
            default: return a % b;
        endcase
    endfunction

    function automatic int lat_of(input logic [2:0] f,
                                  input logic [31:0] a,
                                  input logic [31:0] b);
        logic        sgn;
        logic [31:0] ma, mb;
        bit          special;
        sgn     = !f[0];
        ma      = (sgn && a[31]) ? 32'(-a) : a;
        mb      = (sgn && b[31]) ? 32'(-b) : b;
        special = (b == 32'd0) || (sgn && a == 32'h8000_0000 && b == 32'hFFFF_FFFF)
                  || (ma < mb);
        if (EARLY && special) return 1;
        return DIV_LATENCY;
    endfunction

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
        checks++;
        if (act !== req) begin
            errors++;
            $display("FAIL %s actual=%h required=%h", name, act, req);
        end
    endtask

    task automatic launch(input logic [2:0] f, input logic [31:0] a, input logic [31:0] b);
        @(posedge clk); #1;
        fun3         = f;
        dividend     = a;
        divisor      = b;
        start        = 1'b1;
        exp_res      = model(f, a, b);
        exp_done_cyc = cyc + lat_of(f, a, b);
        exp_active   = 1'b1;
    endtask

    // Launch, hold start through DONE, and pin the result to a hand value.
    task automatic run_op(input string name, input logic [2:0] f, input logic [31:0] a,
                          input logic [31:0] b, input logic [31:0] lit);
        launch(f, a, b);
        while (cyc < exp_done_cyc) begin
            @(posedge clk); #1;
        end
        @(negedge clk);
        chk({name, "_done"}, 32'(done), 32'd1);
        chk(name, result, lit);
    endtask

    task automatic go_idle();
        @(posedge clk); #1;
        start      = 1'b0;
        exp_active = 1'b0;
    endtask

    initial begin
        int t0;
        reset    = 1'b1;
        start    = 1'b0;
        flush    = 1'b0;
        fun3     = 3'b100;
        dividend = '0;
        divisor  = '0;

        fork
            // Per-cycle comparison against the expected transaction.
            forever begin
                @(negedge clk);
                begin
                    logic        e_stall, e_done;
                    logic [31:0] e_res;
                    e_stall = exp_active && (cyc < exp_done_cyc);
                    e_done  = exp_active && (cyc == exp_done_cyc);
                    e_res   = e_done ? exp_res : 32'd0;
                    chk($sformatf("stall@%0d", cyc), 32'(divide_stall), 32'(e_stall));
                    chk($sformatf("done@%0d", cyc), 32'(done), 32'(e_done));
                    chk($sformatf("result@%0d", cyc), result, e_res);
                end
            end

            begin
                repeat (2) @(negedge clk);
                #1;
                chk("rst_stall", 32'(divide_stall), 32'd0);
                chk("rst_done", 32'(done), 32'd0);
                chk("rst_result", result, 32'd0);
                #1 reset = 1'b0;

                run_op("div_20_m3", DIV, 32'h0000_0014, 32'hFFFF_FFFD, 32'hFFFF_FFFA);
                run_op("rem_20_m3", REM, 32'h0000_0014, 32'hFFFF_FFFD, 32'h0000_0002);
                run_op("divu_max_2", DIVU, 32'hFFFF_FFFF, 32'h0000_0002, 32'h7FFF_FFFF);
                run_op("remu_max_2", REMU, 32'hFFFF_FFFF, 32'h0000_0002, 32'h0000_0001);
                run_op("div_m7_0", DIV, 32'hFFFF_FFF9, 32'h0000_0000, 32'hFFFF_FFFF);
                run_op("rem_m7_0", REM, 32'hFFFF_FFF9, 32'h0000_0000, 32'hFFFF_FFF9);
                run_op("div_ovf", DIV, 32'h8000_0000, 32'hFFFF_FFFF, 32'h8000_0000);
                run_op("rem_ovf", REM, 32'h8000_0000, 32'hFFFF_FFFF, 32'h0000_0000);
                run_op("div_5_9", DIV, 32'h0000_0005, 32'h0000_0009, 32'h0000_0000);
                run_op("rem_m3_20", REM, 32'hFFFF_FFFD, 32'h0000_0014, 32'hFFFF_FFFD);
                run_op("divu_m100_m7", DIVU, 32'hFFFF_FF9C, 32'hFFFF_FFF9, 32'h0000_0000);
                run_op("rem_m100_7", REM, 32'hFFFF_FF9C, 32'h0000_0007, 32'hFFFF_FFFE);
                go_idle();
                repeat (2) @(posedge clk);

                // Flush ten cycles into a DIVU, then restart two cycles later.
                launch(DIVU, 32'hFFFF_FFFF, 32'h0000_0002);
                t0 = cyc;
                while (cyc < t0 + 10) begin
                    @(posedge clk); #1;
                end
                flush      = 1'b1;
                start      = 1'b0;
                exp_active = 1'b0;
                @(posedge clk); #1;
                flush = 1'b0;
                chk("flush_state_idle", 32'(dut.r_state), 32'(IDLE));
                run_op("divu_after_flush", DIVU, 32'h1234_5678, 32'h0000_0010, 32'h0123_4567);
                go_idle();

                // Asynchronous reset in the middle of BUSY.
                launch(DIVU, 32'd1000, 32'd3);
                t0 = cyc;
                while (cyc < t0 + 5) begin
                    @(posedge clk); #1;
                end
                #2;
                start      = 1'b0;
                reset      = 1'b1;
                exp_active = 1'b0;
                #1;
                chk("midrst_stall", 32'(divide_stall), 32'd0);
                chk("midrst_done", 32'(done), 32'd0);
                chk("midrst_result", result, 32'd0);
                @(negedge clk);
                #2 reset = 1'b0;
                run_op("div_100_7", DIV, 32'd100, 32'd7, 32'd14);
                go_idle();
                repeat (3) @(posedge clk);
                @(negedge clk);
            end
        join_any
        disable fork;

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
